// File: rtl/udp_tx_arb.sv
`timescale 1ns/1ps
// udp_tx_arb: round-robin N-channel transmit arbiter in front of udp_tx.
// Optional watchdog on a stuck frame: define UDP_ARB_TIMEOUT_EN.
// Ports:
//   clk, rst_n          gmii_tx_clk, async active-low reset
//   ch_start/byte_num/  per-channel request, length, dest IP, data
//   des_ip/data
//   ch_req/done/err     per-channel tx_req, done pulse, reject pulse
//   tx_start_en/        drive udp_tx; tx_req/tx_done come back
//   tx_byte_num/des_ip/
//   tx_data
//   busy, grant_id      status
module udp_tx_arb #(
  parameter int CH_NUM      = 4,
  parameter int MAX_LEN     = 1472,
  parameter int IFG_CYC     = 12,
  parameter int TIMEOUT_CYC = 65535,
  localparam int IDW        = $clog2(CH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_NUM-1:0]    ch_start,
  input  logic [CH_NUM*16-1:0] ch_byte_num,
  input  logic [CH_NUM*32-1:0] ch_des_ip,
  input  logic [CH_NUM*8-1:0]  ch_data,
  output logic [CH_NUM-1:0]    ch_req,
  output logic [CH_NUM-1:0]    ch_done,
  output logic [CH_NUM-1:0]    ch_err,
  output logic                 tx_start_en,
  output logic [15:0]          tx_byte_num,
  output logic [31:0]          des_ip,
  output logic [7:0]           tx_data,
  input  logic                 tx_req,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  localparam logic [15:0] MAXL = 16'(MAX_LEN);
  localparam logic [15:0] GAP_LAST =
    (IFG_CYC > 0) ? 16'(IFG_CYC - 1) : 16'd0;
  localparam logic [IDW-1:0] LAST_CH = IDW'(CH_NUM - 1);
  localparam logic [4:0] CHN5 = 5'(CH_NUM);

  state_t            r_state;
  logic [CH_NUM-1:0] r_pend;
  logic [CH_NUM-1:0] r_done;
  logic [CH_NUM-1:0] r_err;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_grant;
  logic [15:0]       r_len;
  logic [31:0]       r_ip;
  logic              r_start;
  logic [15:0]       r_gap_cnt;
`ifdef UDP_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0]       r_to_cnt;
`endif

  logic              w_hit;
  logic [IDW-1:0]    w_sel;
  logic [IDW-1:0]    w_nxt;
  logic [4:0]        w_idx;
  logic [15:0]       w_sel_len;
  logic              w_bad;
  logic [CH_NUM-1:0] w_sel_oh;
  logic [CH_NUM-1:0] w_gnt_oh;
  logic [CH_NUM-1:0] w_clr;

  // Walk from rr_ptr upward; the loop runs backwards so the
  // candidate closest to rr_ptr is the last one to win.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      w_idx = 5'(r_rr_ptr) + 5'(i);
      if (w_idx >= CHN5) w_idx = w_idx - CHN5;
      if (r_pend[IDW'(w_idx)]) begin
        w_hit = 1'b1;
        w_sel = IDW'(w_idx);
      end
    end
  end

  always_comb begin
    w_sel_oh = '0;
    w_sel_oh[w_sel] = 1'b1;
    w_gnt_oh = '0;
    w_gnt_oh[r_grant] = 1'b1;
  end

  assign w_sel_len = ch_byte_num[16*w_sel +: 16];
  assign w_bad = (w_sel_len == 16'd0) || (w_sel_len > MAXL);
  assign w_nxt = (w_sel == LAST_CH) ? '0 : w_sel + 1'b1;
  assign w_clr = (r_state == S_IDLE && w_hit) ? w_sel_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_len     <= '0;
      r_ip      <= '0;
      r_start   <= 1'b0;
      r_gap_cnt <= '0;
`ifdef UDP_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
`endif
    end else begin
      // A start landing on the bit being granted survives.
      r_pend  <= (r_pend & ~w_clr) | ch_start;
      r_start <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_rr_ptr <= w_nxt;
            if (w_bad) begin
              r_err <= w_sel_oh;
            end else begin
              r_grant <= w_sel;
              r_len   <= w_sel_len;
              r_ip    <= ch_des_ip[32*w_sel +: 32];
              r_start <= 1'b1;
              r_state <= S_START;
`ifdef UDP_ARB_TIMEOUT_EN
              r_to_cnt <= '0;
`endif
            end
          end
        end
        S_START: begin
          r_state <= S_WAIT;
`ifdef UDP_ARB_TIMEOUT_EN
          r_to_cnt <= r_to_cnt + 16'd1;
`endif
        end
        S_WAIT: begin
          if (tx_done) begin
            r_done    <= w_gnt_oh;
            r_gap_cnt <= '0;
            r_state   <= (IFG_CYC == 0) ? S_IDLE : S_GAP;
`ifdef UDP_ARB_TIMEOUT_EN
          end else if (r_to_cnt == TO_LAST) begin
            // Watchdog counts from START, so the abort
            // pulse lands TIMEOUT_CYC cycles after it.
            r_err     <= w_gnt_oh;
            r_gap_cnt <= '0;
            r_state   <= (IFG_CYC == 0) ? S_IDLE : S_GAP;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
`endif
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_req = (r_state == S_WAIT && tx_req) ? w_gnt_oh : '0;
  assign tx_data = (r_state == S_WAIT) ?
                   ch_data[8*r_grant +: 8] : 8'd0;
  assign ch_done     = r_done;
  assign ch_err      = r_err;
  assign tx_start_en = r_start;
  assign tx_byte_num = r_len;
  assign des_ip      = r_ip;
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant;

endmodule

// File: tb/tb_udp_tx_arb.sv
`timescale 1ns/1ps
// tb_udp_tx_arb: directed scoreboard bench for udp_tx_arb.
// Expected grants/dones/errors are queued; a monitor pops them.
module tb_udp_tx_arb;

  localparam int CH   = 4;
  localparam int IFG  = 12;
  localparam int MAXL = 1472;
  localparam int TO   = 100;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   ch_start = '0;
  logic [CH*16-1:0] ch_byte_num = '0;
  logic [CH*32-1:0] ch_des_ip = '0;
  logic [CH*8-1:0] ch_data = '0;
  logic [CH-1:0]   ch_req, ch_done, ch_err;
  logic            tx_start_en;
  logic [15:0]     tx_byte_num;
  logic [31:0]     des_ip;
  logic [7:0]      tx_data;
  logic            tx_req = 1'b0;
  logic            tx_done = 1'b0;
  logic            busy;
  logic [1:0]      grant_id;

  udp_tx_arb #(
    .CH_NUM(CH), .MAX_LEN(MAXL),
    .IFG_CYC(IFG), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_start(ch_start), .ch_byte_num(ch_byte_num),
    .ch_des_ip(ch_des_ip), .ch_data(ch_data),
    .ch_req(ch_req), .ch_done(ch_done), .ch_err(ch_err),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .des_ip(des_ip), .tx_data(tx_data),
    .tx_req(tx_req), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    int          len;
    logic [31:0] ip;
  } st_t;

  st_t q_start[$];
  int  q_done[$];
  int  q_err[$];
  int  n_vec = 0;
  int  n_bad = 0;
  st_t m_e;
  int  m_c;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h @%0d", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start_en) begin
        n_vec++;
        if (q_start.size() == 0) begin
          n_bad++;
          $display("FAIL start_unexpected ch=%0d @%0d",
                   grant_id, cyc);
        end else begin
          m_e = q_start.pop_front();
          if (grant_id !== 2'(m_e.ch) ||
              tx_byte_num !== 16'(m_e.len) ||
              des_ip !== m_e.ip) begin
            n_bad++;
            $display("FAIL start got ch=%0d len=%0d ip=%h want ch=%0d len=%0d ip=%h",
                     grant_id, tx_byte_num, des_ip,
                     m_e.ch, m_e.len, m_e.ip);
          end
        end
      end
      for (int k = 0; k < CH; k++) begin
        if (ch_done[k]) begin
          n_vec++;
          if (q_done.size() == 0) begin
            n_bad++;
            $display("FAIL done_unexpected ch=%0d @%0d", k, cyc);
          end else begin
            m_c = q_done.pop_front();
            if (m_c != k) begin
              n_bad++;
              $display("FAIL done got ch=%0d want ch=%0d", k, m_c);
            end
          end
        end
        if (ch_err[k]) begin
          n_vec++;
          if (q_err.size() == 0) begin
            n_bad++;
            $display("FAIL err_unexpected ch=%0d @%0d", k, cyc);
          end else begin
            m_c = q_err.pop_front();
            if (m_c != k) begin
              n_bad++;
              $display("FAIL err got ch=%0d want ch=%0d", k, m_c);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setch(input int ch, input int len,
                       input logic [31:0] ip);
    ch_byte_num[16*ch +: 16] = 16'(len);
    ch_des_ip[32*ch +: 32] = ip;
  endtask

  task automatic expect_start(input int ch, input int len,
                              input logic [31:0] ip);
    st_t e;
    e.ch = ch;
    e.len = len;
    e.ip = ip;
    q_start.push_back(e);
  endtask

  task automatic pulse(input logic [CH-1:0] m, output int pc);
    pc = cyc;
    ch_start = m;
    tick();
    ch_start = '0;
  endtask

  task automatic wait_start(output int sc);
    sc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_start_en) begin
        sc = cyc;
        break;
      end
    end
    if (sc < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL start_timeout @%0d", cyc);
    end
    tick();
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout @%0d", cyc);
    end
    tick();
  endtask

  // Serve one frame: mirror checks on ch_req/tx_data, then tx_done.
  task automatic run_frame(input int ch, input int nreq,
                           output int sc, output int dc);
    logic [CH-1:0] er;
    dc = -1;
    wait_start(sc);
    if (sc < 0) return;
    for (int i = 0; i < nreq; i++) begin
      for (int k = 0; k < CH; k++)
        ch_data[8*k +: 8] = 8'(k * 16 + i);
      tx_req = (i % 3) != 2;
      er = '0;
      if (tx_req) er[ch] = 1'b1;
      @(negedge clk);
      chk("ch_req", 128'(ch_req), 128'(er));
      chk("tx_data", 128'(tx_data), 128'(8'(ch * 16 + i)));
      tick();
    end
    tx_req = 1'b0;
    tx_done = 1'b1;
    dc = cyc;
    q_done.push_back(ch);
    tick();
    tx_done = 1'b0;
  endtask

  task automatic no_start_window(input string nm);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk({nm, "_busy"}, 128'(busy), 128'(0));
      chk({nm, "_start"}, 128'(tx_start_en), 128'(0));
      tick();
    end
  endtask

  function automatic logic [127:0] all_out();
    return 128'({ch_req, ch_done, ch_err, tx_start_en,
                 tx_byte_num, des_ip, tx_data, busy, grant_id});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog @%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, sc, dc, dc3, ec;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_out(), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin from reset: 0,1,2,3.
    setch(0, 100, 32'h0A000001);
    setch(1, 200, 32'h0A000002);
    setch(2, 300, 32'h0A000003);
    setch(3, 400, 32'h0A000004);
    expect_start(0, 100, 32'h0A000001);
    expect_start(1, 200, 32'h0A000002);
    expect_start(2, 300, 32'h0A000003);
    expect_start(3, 400, 32'h0A000004);
    pulse(4'b1111, pc);
    run_frame(0, 4, sc, dc);
    chk("rr_start_lat", 128'(sc - pc), 128'(2));
    run_frame(1, 4, sc, dc);
    run_frame(2, 4, sc, dc);
    run_frame(3, 4, sc, dc3);
    // Re-request 0 and 3 inside the last gap.
    setch(0, 50, 32'h0B000000);
    setch(3, 60, 32'h0B000003);
    expect_start(0, 50, 32'h0B000000);
    expect_start(3, 60, 32'h0B000003);
    pulse(4'b1001, pc);
    run_frame(0, 3, sc, dc);
    // 13 idle cycles strictly between tx_done and tx_start_en.
    chk("ifg_gap", 128'(sc - dc3), 128'(IFG + 2));
    run_frame(3, 3, sc, dc);
    wait_idle();

    // Single request on channel 2.
    setch(2, 64, 32'hC0A80166);
    expect_start(2, 64, 32'hC0A80166);
    pulse(4'b0100, pc);
    run_frame(2, 64, sc, dc);
    chk("single_start_lat", 128'(sc - pc), 128'(2));
    wait_idle();

    // Illegal lengths, then the largest legal one.
    setch(1, 0, 32'h01010101);
    q_err.push_back(1);
    pulse(4'b0010, pc);
    no_start_window("len0");
    setch(1, MAXL + 1, 32'h01010101);
    q_err.push_back(1);
    pulse(4'b0010, pc);
    no_start_window("len1473");
    setch(1, MAXL, 32'h01010102);
    expect_start(1, MAXL, 32'h01010102);
    pulse(4'b0010, pc);
    run_frame(1, 3, sc, dc);
    wait_idle();

    // Start on channel 0 in its own grant cycle.
    setch(0, 80, 32'hC0A80001);
    expect_start(0, 80, 32'hC0A80001);
    expect_start(0, 80, 32'hC0A80001);
    pulse(4'b0001, pc);
    pulse(4'b0001, pc);
    run_frame(0, 2, sc, dc);
    run_frame(0, 2, sc, dc);
    wait_idle();

    // Reset in WAIT_DONE.
    setch(2, 30, 32'hC0A80002);
    expect_start(2, 30, 32'hC0A80002);
    pulse(4'b0100, pc);
    wait_start(sc);
    tx_req = 1'b1;
    @(negedge clk);
    chk("pre_reset_req", 128'(ch_req), 128'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), 128'(0));
    tx_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // rr_ptr back at 0, so channel 1 precedes channel 3.
    setch(1, 11, 32'hC0A80011);
    setch(3, 33, 32'hC0A80033);
    expect_start(1, 11, 32'hC0A80011);
    expect_start(3, 33, 32'hC0A80033);
    pulse(4'b1010, pc);
    run_frame(1, 2, sc, dc);
    run_frame(3, 2, sc, dc);
    wait_idle();

`ifdef UDP_ARB_TIMEOUT_EN
    setch(2, 10, 32'hC0A800AA);
    expect_start(2, 10, 32'hC0A800AA);
    pulse(4'b0100, pc);
    wait_start(sc);
    q_err.push_back(2);
    ec = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ch_err[2]) begin
        ec = cyc;
        break;
      end
    end
    chk("timeout_lat", 128'(ec - sc), 128'(TO));
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_idle();
`else
    ec = 0;
`endif

    repeat (4) tick();
    chk("scoreboard_empty",
        128'(q_start.size() + q_done.size() + q_err.size()),
        128'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
